// File: rtl/p_clic_ctrl_if.sv
// Interrupt/config/handshake bundle between p_clic_ctrl (slave) and the core plus
// config agent (master).
interface p_clic_ctrl_if #(
    parameter int NrSources  = 4,
    parameter int PrioWidth  = 3,
    parameter int StackDepth = (1 << PrioWidth) - 1,
    parameter int SrcWidth   = $clog2(NrSources),
    parameter int DepthWidth = $clog2(StackDepth + 1)
);
    logic [NrSources-1:0]  irq_i;
    logic                  cfg_we;
    logic [SrcWidth-1:0]   cfg_idx;
    logic [PrioWidth-1:0]  cfg_prio;
    logic                  cfg_en;
    logic                  req_o;
    logic [SrcWidth-1:0]   req_index_o;
    logic [PrioWidth-1:0]  req_prio_o;
    logic                  take_i;
    logic                  complete_i;
    logic [PrioWidth-1:0]  threshold_o;
    logic [DepthWidth-1:0] depth_o;
    logic                  err_o;

    modport slave (
        input  irq_i, cfg_we, cfg_idx, cfg_prio, cfg_en, take_i, complete_i,
        output req_o, req_index_o, req_prio_o, threshold_o, depth_o, err_o
    );

    modport master (
        output irq_i, cfg_we, cfg_idx, cfg_prio, cfg_en, take_i, complete_i,
        input  req_o, req_index_o, req_prio_o, threshold_o, depth_o, err_o
    );
endinterface

// File: rtl/p_clic_ctrl.sv
// Interrupt sequencing controller: pending/enable/priority state, arbitration against a
// nested threshold stack, and a req/take/complete handshake. P_CLIC_EDGE_EN selects edge mode.
module p_clic_ctrl #(
    parameter int NrSources  = 4,
    parameter int PrioWidth  = 3,
    parameter int StackDepth = (1 << PrioWidth) - 1
) (
    input logic          clk,
    input logic          reset,
    p_clic_ctrl_if.slave bus
);
    localparam int SrcWidth   = $clog2(NrSources);
    localparam int DepthWidth = $clog2(StackDepth + 1);
    localparam logic [DepthWidth-1:0] DepthMax = DepthWidth'(StackDepth);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SETTLE
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [NrSources-1:0]  r_p;
    logic [NrSources-1:0]  r_en;
    logic [PrioWidth-1:0]  r_prio [NrSources];
    logic                  r_req;
    logic [SrcWidth-1:0]   r_req_idx;
    logic [PrioWidth-1:0]  r_req_prio;
    logic [PrioWidth-1:0]  r_thr;
    logic [DepthWidth-1:0] r_depth;
    logic                  r_err;
    logic [PrioWidth-1:0]  r_stack [StackDepth];

    logic                  w_found;
    logic [SrcWidth-1:0]   w_win_idx;
    logic [PrioWidth-1:0]  w_win_prio;
    logic                  w_take_ok;
    logic                  w_cmpl_ok;
    logic                  w_err;
    logic [DepthWidth-1:0] w_pop_idx;

    // Highest priority above threshold wins; >= on ties lets the later (higher) index win.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_win_prio = '0;
        for (int i = 0; i < NrSources; i++) begin
            if (r_p[i] && r_en[i] && (r_prio[i] > r_thr) &&
                (!w_found || (r_prio[i] >= w_win_prio))) begin
                w_found    = 1'b1;
                w_win_idx  = SrcWidth'(i);
                w_win_prio = r_prio[i];
            end
        end
    end

    always_comb begin
        w_take_ok = bus.take_i && r_req && (r_depth != DepthMax);
        w_cmpl_ok = bus.complete_i && !bus.take_i && (r_depth != '0);
        w_err     = (bus.take_i && !r_req) ||
                    (bus.take_i && (r_depth == DepthMax)) ||
                    (bus.take_i && bus.complete_i) ||
                    (bus.complete_i && (r_depth == '0));
        w_pop_idx = r_depth - DepthWidth'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_found) w_state_nxt = S_REQ;
            S_REQ:    if (w_take_ok) w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_req_idx  <= '0;
            r_req_prio <= '0;
            r_thr      <= '0;
            r_depth    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;
            if ((r_state == S_IDLE) && w_found) begin
                r_req      <= 1'b1;
                r_req_idx  <= w_win_idx;
                r_req_prio <= w_win_prio;
            end else if (w_take_ok) begin
                r_req <= 1'b0;
            end
            if (w_take_ok) begin
                r_thr   <= r_req_prio;
                r_depth <= r_depth + DepthWidth'(1);
            end else if (w_cmpl_ok) begin
                r_thr   <= r_stack[w_pop_idx];
                r_depth <= w_pop_idx;
            end
        end
    end

    // NOTE: the stack is plain storage; depth alone says which entries are live, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_take_ok) r_stack[r_depth] <= r_thr;
    end

`ifdef P_CLIC_EDGE_EN
    logic [NrSources-1:0] r_irq_q;
    logic [NrSources-1:0] w_clr;

    always_comb begin
        w_clr = '0;
        if (w_take_ok) w_clr[r_req_idx] = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p  <= '0;
            r_en <= '0;
            for (int i = 0; i < NrSources; i++) r_prio[i] <= '0;
`ifdef P_CLIC_EDGE_EN
            r_irq_q <= '0;
`endif
        end else begin
            if (bus.cfg_we) begin
                r_en[bus.cfg_idx]   <= bus.cfg_en;
                r_prio[bus.cfg_idx] <= bus.cfg_prio;
            end
`ifdef P_CLIC_EDGE_EN
            // A new edge on the source being taken is a fresh event, so set beats clear.
            r_irq_q <= bus.irq_i;
            r_p     <= (r_p & ~w_clr) | (bus.irq_i & ~r_irq_q);
`else
            r_p <= bus.irq_i;
`endif
        end
    end

    assign bus.req_o       = r_req;
    assign bus.req_index_o = r_req_idx;
    assign bus.req_prio_o  = r_req_prio;
    assign bus.threshold_o = r_thr;
    assign bus.depth_o     = r_depth;
    assign bus.err_o       = r_err;
endmodule

// File: tb/tb_p_clic_ctrl.sv
// Self-checking bench for p_clic_ctrl: directed scenarios then random traffic, every
// cycle compared against a behavioural model built on a queue-based threshold stack.
module tb_p_clic_ctrl;
    localparam int NR    = 4;
    localparam int PW    = 3;
    localparam int SDEPTH = (1 << PW) - 1;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_SETTLE = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    p_clic_ctrl_if bus_if ();

    p_clic_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_p [NR];
    int m_irq_q [NR];
    int m_en [NR];
    int m_prio [NR];
    int m_stack [$];
    int m_thr, m_req, m_idx, m_rprio, m_phase, m_err;
    logic [NR-1:0] d_irq;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_p[i] = 0; m_irq_q[i] = 0; m_en[i] = 0; m_prio[i] = 0;
        end
        m_stack.delete();
        m_thr = 0; m_req = 0; m_idx = 0; m_rprio = 0; m_phase = PH_IDLE; m_err = 0;
    endtask

    // One clock of the controller's rules, evaluated on pre-edge state and inputs.
    task automatic model_step(input int rst, input logic [NR-1:0] irq, input int we,
                              input int idx, input int prio, input int en,
                              input int take, input int cmpl);
        int best, take_ok, cmpl_ok, n_phase;
        if (rst != 0) begin
            model_reset();
            return;
        end
        best = -1;
        for (int i = 0; i < NR; i++)
            if (m_p[i] != 0 && m_en[i] != 0 && m_prio[i] > m_thr && m_prio[i] * NR + i > best)
                best = m_prio[i] * NR + i;
        take_ok = (take != 0 && m_req != 0 && m_stack.size() < SDEPTH) ? 1 : 0;
        cmpl_ok = (cmpl != 0 && take == 0 && m_stack.size() > 0) ? 1 : 0;
        m_err = ((take != 0 && take_ok == 0) || (cmpl != 0 && cmpl_ok == 0)) ? 1 : 0;
`ifdef P_CLIC_EDGE_EN
        for (int i = 0; i < NR; i++) begin
            if (take_ok != 0 && i == m_idx) m_p[i] = 0;
            if (irq[i] && m_irq_q[i] == 0) m_p[i] = 1;
            m_irq_q[i] = int'(irq[i]);
        end
`else
        for (int i = 0; i < NR; i++) m_p[i] = int'(irq[i]);
`endif
        if (take_ok != 0) begin
            m_stack.push_back(m_thr);
            m_thr = m_rprio;
        end else if (cmpl_ok != 0) begin
            m_thr = m_stack.pop_back();
        end
        n_phase = m_phase;
        if (m_phase == PH_IDLE && best >= 0) begin
            n_phase = PH_REQ; m_req = 1; m_idx = best % NR; m_rprio = best / NR;
        end else if (m_phase == PH_REQ && take_ok != 0) begin
            n_phase = PH_SETTLE; m_req = 0;
        end else if (m_phase == PH_SETTLE) begin
            n_phase = PH_IDLE;
        end
        m_phase = n_phase;
        if (we != 0) begin
            m_en[idx] = en; m_prio[idx] = prio;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare on the falling edge.
    task automatic tick(input int rst, input logic [NR-1:0] irq, input int we, input int idx,
                        input int prio, input int en, input int take, input int cmpl);
        reset              = (rst != 0);
        bus_if.irq_i       = irq;
        bus_if.cfg_we      = (we != 0);
        bus_if.cfg_idx     = 2'(idx);
        bus_if.cfg_prio    = 3'(prio);
        bus_if.cfg_en      = (en != 0);
        bus_if.take_i      = (take != 0);
        bus_if.complete_i  = (cmpl != 0);
        model_step(rst, irq, we, idx, prio, en, take, cmpl);
        @(negedge clk);
        check("req_o", int'(bus_if.req_o), m_req);
        check("threshold_o", int'(bus_if.threshold_o), m_thr);
        check("depth_o", int'(bus_if.depth_o), m_stack.size());
        check("err_o", int'(bus_if.err_o), m_err);
        if (m_req != 0) begin
            check("req_index_o", int'(bus_if.req_index_o), m_idx);
            check("req_prio_o", int'(bus_if.req_prio_o), m_rprio);
        end
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) tick(0, d_irq, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_cycle();
        tick(1, d_irq, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int idx, input int prio, input int en);
        tick(0, d_irq, 1, idx, prio, en, 0, 0);
    endtask

    task automatic take_req();
        tick(0, d_irq, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic complete_req();
        tick(0, d_irq, 0, 0, 0, 0, 0, 1);
    endtask

    // Raise lines, let the request form, take it, and let SETTLE pass.
    task automatic raise_and_take(input logic [NR-1:0] mask);
        d_irq = mask;
        nop(2);
        take_req();
        nop(1);
    endtask

    initial begin
        model_reset();
        d_irq = '0;
        @(negedge clk);

        // Reset state, all sources disabled with every line high
        rst_cycle();
        check("rst_req", int'(bus_if.req_o), 0);
        check("rst_idx", int'(bus_if.req_index_o), 0);
        check("rst_prio", int'(bus_if.req_prio_o), 0);
        check("rst_thr", int'(bus_if.threshold_o), 0);
        check("rst_depth", int'(bus_if.depth_o), 0);
        d_irq = 4'hF;
        nop(20);

        // Equal priorities: highest index wins, equal-to-threshold masks the rest
        rst_cycle();
        d_irq = '0;
        for (int i = 0; i < NR; i++) cfg(i, 1, 1);
        d_irq = 4'hF;
        nop(1);
        check("t2_before", int'(bus_if.req_o), 0);
        nop(1);
        check("t2_req", int'(bus_if.req_o), 1);
        check("t2_idx", int'(bus_if.req_index_o), 3);
        check("t2_prio", int'(bus_if.req_prio_o), 1);
        take_req();
        check("t2_thr", int'(bus_if.threshold_o), 1);
        check("t2_depth", int'(bus_if.depth_o), 1);
        nop(6);
        check("t2_masked", int'(bus_if.req_o), 0);

        // Two-level nesting then unwinding
        rst_cycle();
        d_irq = '0;
        cfg(0, 2, 1);
        cfg(1, 5, 1);
        d_irq = 4'b0001;
        nop(2);
        check("t3_idx0", int'(bus_if.req_index_o), 0);
        take_req();
        check("t3_thr2", int'(bus_if.threshold_o), 2);
        d_irq = 4'b0011;
        nop(2);
        check("t3_idx1", int'(bus_if.req_index_o), 1);
        take_req();
        check("t3_thr5", int'(bus_if.threshold_o), 5);
        check("t3_depth2", int'(bus_if.depth_o), 2);
        d_irq = '0;
        complete_req();
        check("t3_pop_thr", int'(bus_if.threshold_o), 2);
        complete_req();
        check("t3_pop2_thr", int'(bus_if.threshold_o), 0);
        check("t3_pop2_depth", int'(bus_if.depth_o), 0);

        // Protocol violations
        rst_cycle();
        take_req();
        check("t4_take_idle_err", int'(bus_if.err_o), 1);
        nop(1);
        complete_req();
        check("t4_cmpl_empty_err", int'(bus_if.err_o), 1);
        cfg(2, 3, 1);
        d_irq = 4'b0100;
        nop(2);
        tick(0, d_irq, 0, 0, 0, 0, 1, 1);
        check("t4_both_err", int'(bus_if.err_o), 1);
        check("t4_both_thr", int'(bus_if.threshold_o), 3);
        check("t4_both_depth", int'(bus_if.depth_o), 1);
        d_irq = '0;
        complete_req();

        // Frozen request while a better source arrives
        rst_cycle();
        cfg(0, 2, 1);
        cfg(3, 6, 1);
        d_irq = 4'b0001;
        nop(2);
        d_irq = 4'b1001;
        nop(3);
        check("t5_frozen_idx", int'(bus_if.req_index_o), 0);
        take_req();
        nop(2);
        check("t5_new_idx", int'(bus_if.req_index_o), 3);
        check("t5_new_prio", int'(bus_if.req_prio_o), 6);

        // Reset at depth 3 with a request outstanding
        rst_cycle();
        d_irq = '0;
        for (int i = 0; i < NR; i++) cfg(i, i + 1, 1);
        raise_and_take(4'b0001);
        raise_and_take(4'b0011);
        raise_and_take(4'b0111);
        d_irq = 4'hF;
        nop(2);
        check("t6_pre_depth", int'(bus_if.depth_o), 3);
        check("t6_pre_req", int'(bus_if.req_o), 1);
        rst_cycle();
        check("t6_req", int'(bus_if.req_o), 0);
        check("t6_thr", int'(bus_if.threshold_o), 0);
        check("t6_depth", int'(bus_if.depth_o), 0);
        nop(4);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            int rst, we, take, cmpl;
            rst  = ($urandom_range(0, 299) == 0) ? 1 : 0;
            we   = ($urandom_range(0, 6) == 0) ? 1 : 0;
            take = ($urandom_range(0, 3) == 0) ? 1 : 0;
            cmpl = ($urandom_range(0, 7) == 0) ? 1 : 0;
            for (int b = 0; b < NR; b++)
                if ($urandom_range(0, 7) == 0) d_irq[b] = ~d_irq[b];
            tick(rst, d_irq, we, $urandom_range(0, NR - 1), $urandom_range(0, (1 << PW) - 1),
                 ($urandom_range(0, 3) != 0) ? 1 : 0, take, cmpl);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
